// File: rtl/data_axil_bridge.sv
// data_axil_bridge
//   Converts a simple core data port (req/gnt/rvalid handshake) into an
//   AXI4-Lite master. At most one transaction is in flight at a time.
//
// Ports
//   clk_i, rst_ni        : clock (rising edge), asynchronous active-low reset
//   data_req_i/gnt_o     : core request, granted combinationally while idle
//   data_we_i/be_i/addr_i/wdata_i : request attributes, captured on grant
//   data_rvalid_o        : one-cycle response pulse
//   data_rdata_o/err_o   : response data (0 for stores) and error flag
//   m_aw*/m_w*/m_b*      : AXI4-Lite write address, write data, write response
//   m_ar*/m_r*           : AXI4-Lite read address, read data
module data_axil_bridge #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic                    data_we_i,
  input  logic [DataWidth/8-1:0]  data_be_i,
  input  logic [AddressWidth-1:0] data_addr_i,
  input  logic [DataWidth-1:0]    data_wdata_i,
  output logic [DataWidth-1:0]    data_rdata_o,
  output logic                    data_err_o,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [AddressWidth-1:0] m_awaddr,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DataWidth-1:0]    m_wdata,
  output logic [DataWidth/8-1:0]  m_wstrb,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [AddressWidth-1:0] m_araddr,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [DataWidth-1:0]    m_rdata,
  input  logic [1:0]              m_rresp
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_e;

  state_e state_q, state_d;

  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    rvalid_q, rvalid_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    capture;
  logic                    gnt;
  logic                    aw_fin, w_fin;

  logic [AddressWidth-1:0] addr_q;
  logic [DataWidth/8-1:0]  be_q;
  logic [DataWidth-1:0]    wdata_q;

  // SLVERR (2'b10) and DECERR (2'b11) are errors; OKAY and EXOKAY are not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == 2'b10) || (resp == 2'b11);
  endfunction

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    capture   = 1'b0;
    gnt       = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    aw_fin    = 1'b0;
    w_fin     = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt = data_req_i;
        if (data_req_i) begin
          capture   = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = data_we_i ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          rvalid_d = 1'b1;
          rdata_d  = m_rdata;
          err_d    = resp_is_err(m_rresp);
          state_d  = IDLE;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; each valid drops once its own
        // handshake is recorded, in whichever order the slave accepts them.
        m_awvalid = !aw_done_q;
        m_wvalid  = !w_done_q;
        aw_fin    = aw_done_q || m_awready;
        w_fin     = w_done_q || m_wready;
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          rvalid_d = 1'b1;
          rdata_d  = '0;
          err_d    = resp_is_err(m_bresp);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant is masked while reset is held so every output reads 0 in reset.
  assign data_gnt_o    = gnt && rst_ni;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

  // Payload is zeroed whenever its valid is low.
  assign m_araddr = m_arvalid ? addr_q  : '0;
  assign m_awaddr = m_awvalid ? addr_q  : '0;
  assign m_wdata  = m_wvalid  ? wdata_q : '0;
  assign m_wstrb  = m_wvalid  ? be_q    : '0;

  // ---- control / response register stage ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // ---- request capture stage ----
  always_ff @(posedge clk_i) begin
    if (capture) begin
      addr_q  <= data_addr_i;
      be_q    <= data_be_i;
      wdata_q <= data_wdata_i;
    end
  end

endmodule

// File: tb/tb_data_axil_bridge.sv
// tb_data_axil_bridge
//   Randomized and directed bench for data_axil_bridge. A behavioural
//   AXI4-Lite slave with configurable per-channel wait states and responses
//   sits on the master side; a word-array memory model plus latency rules
//   derived from the wait states provide every expected value.
module tb_data_axil_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  always #5 clk_i = ~clk_i;

  data_axil_bridge #(.DataWidth(32), .AddressWidth(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Slave configuration, written only by the main process.
  int         ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;

  // Slave memory and captured payloads, written only by the slave process.
  logic [31:0] smem [16];
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;

  // Reference memory, written only by the main process.
  logic [31:0] mmem [16];

  // Behavioural AXI4-Lite slave. Acts 1 time unit after each rising edge;
  // handshakes are those where valid and ready were both high at the edge.
  initial begin
    int ar_c, r_c, aw_c, w_c, b_c;
    bit r_pend, b_pend, aw_got, w_got;
    logic p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br;
    for (int i = 0; i < 16; i++) smem[i] = 32'hA5A5_0000 + i;
    smem[0] = 32'hDEADBEEF;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    {p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br} = '0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    cap_araddr = 0; cap_awaddr = 0; cap_wdata = 0; cap_wstrb = 0;
    forever begin
      @(posedge clk_i); #1;
      if (!rst_ni) begin
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        {p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br} = '0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
      end else begin
        if (p_arv && p_arr) begin r_pend = 1; r_c = 0; ar_c = 0; end
        if (p_rv && p_rr) r_pend = 0;
        if (p_awv && p_awr) begin aw_got = 1; aw_c = 0; end
        if (p_wv && p_wr) begin w_got = 1; w_c = 0; end
        if (aw_got && w_got) begin
          for (int b = 0; b < 4; b++)
            if (cap_wstrb[b]) smem[cap_awaddr[5:2]][8*b +: 8] = cap_wdata[8*b +: 8];
          aw_got = 0; w_got = 0; b_pend = 1; b_c = 0;
        end
        if (p_bv && p_br) b_pend = 0;

        m_arready = 0;
        if (m_arvalid) begin
          if (ar_c >= ar_dly) begin m_arready = 1; cap_araddr = m_araddr; end
          else ar_c++;
        end
        m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        if (r_pend) begin
          if (r_c >= r_dly) begin
            m_rvalid = 1; m_rdata = smem[cap_araddr[5:2]]; m_rresp = rresp_cfg;
          end else r_c++;
        end
        m_awready = 0;
        if (m_awvalid) begin
          if (aw_c >= aw_dly) begin m_awready = 1; cap_awaddr = m_awaddr; end
          else aw_c++;
        end
        m_wready = 0;
        if (m_wvalid) begin
          if (w_c >= w_dly) begin m_wready = 1; cap_wdata = m_wdata; cap_wstrb = m_wstrb; end
          else w_c++;
        end
        m_bvalid = 0; m_bresp = 0;
        if (b_pend) begin
          if (b_c >= b_dly) begin m_bvalid = 1; m_bresp = bresp_cfg; end
          else b_c++;
        end
        p_arv = m_arvalid; p_arr = m_arready; p_rv = m_rvalid; p_rr = m_rready;
        p_awv = m_awvalid; p_awr = m_awready; p_wv = m_wvalid; p_wr = m_wready;
        p_bv = m_bvalid; p_br = m_bready;
      end
    end
  end

  // Reference model: applies the request to the word array and derives the
  // expected response from the configured slave response code.
  task automatic model_exp(input logic we, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wd, output logic [31:0] exp_rd,
                           output logic exp_err);
    logic [1:0] resp;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mmem[addr[5:2]][8*b +: 8] = wd[8*b +: 8];
      exp_rd = 32'h0;
      resp   = bresp_cfg;
    end else begin
      exp_rd = mmem[addr[5:2]];
      resp   = rresp_cfg;
    end
    exp_err = (resp == 2'b10) || (resp == 2'b11);
  endtask

  task automatic check_zero(input string tag);
    check_eq(tag, 64'({data_gnt_o, data_rvalid_o, |data_rdata_o, data_err_o,
                       m_awvalid, |m_awaddr, m_wvalid, |m_wdata, |m_wstrb, m_bready,
                       m_arvalid, |m_araddr, m_rready}), 64'h0);
  endtask

  // Present a request and wait (bounded) for its grant.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd);
    @(posedge clk_i); #1;
    data_req_i = 1; data_we_i = we; data_addr_i = addr; data_be_i = be; data_wdata_i = wd;
    #1;
    for (int i = 0; i < 20 && !data_gnt_o; i++) begin @(posedge clk_i); #2; end
    check_eq("gnt", 64'(data_gnt_o), 64'h1);
  endtask

  // Wait for the response following a grant; returns cycles from the grant
  // cycle to the rvalid pulse and the number of cycles each AW/W valid was up.
  task automatic wait_resp(input bit hold, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err,
                           output int lat, output int n_aw, output int n_w);
    int bad, gnt_bad, first_v;
    bad = 0; gnt_bad = 0; n_aw = 0; n_w = 0; first_v = 0;
    for (lat = 1; lat <= 60; lat++) begin
      @(posedge clk_i); #1;
      data_req_i = hold;
      #1;
      if (lat == 1) first_v = we ? int'(m_awvalid && m_wvalid) : int'(m_arvalid);
      n_aw += int'(m_awvalid);
      n_w  += int'(m_wvalid);
      if (m_arvalid ? (m_araddr !== addr) : (m_araddr !== 32'h0)) bad++;
      if (m_awvalid ? (m_awaddr !== addr) : (m_awaddr !== 32'h0)) bad++;
      if (m_wvalid ? (m_wdata !== wd || m_wstrb !== be)
                   : (m_wdata !== 32'h0 || m_wstrb !== 4'h0)) bad++;
      if (data_rvalid_o) break;
      if (data_gnt_o) gnt_bad++;
    end
    check_eq("valid_after_gnt", 64'(first_v), 64'h1);
    check_eq("rvalid_o", 64'(data_rvalid_o), 64'h1);
    check_eq("rdata", 64'(data_rdata_o), 64'(exp_rd));
    check_eq("err", 64'(data_err_o), 64'(exp_err));
    check_eq("payload", 64'(bad), 64'h0);
    check_eq("gnt_busy", 64'(gnt_bad), 64'h0);
    if (we) begin
      check_eq("awaddr", 64'(cap_awaddr), 64'(addr));
      check_eq("wdata", 64'(cap_wdata), 64'(wd));
      check_eq("wstrb", 64'(cap_wstrb), 64'(be));
    end else begin
      check_eq("araddr", 64'(cap_araddr), 64'(addr));
    end
  endtask

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output int lat, output int n_aw,
                        output int n_w);
    logic [31:0] e_rd;
    logic        e_err;
    model_exp(we, addr, be, wd, e_rd, e_err);
    issue(we, addr, be, wd);
    wait_resp(0, we, addr, be, wd, e_rd, e_err, lat, n_aw, n_w);
    @(posedge clk_i); #2;
    check_eq("rvalid_pulse", 64'(data_rvalid_o), 64'h0);
  endtask

  int          lat, na, nw, exp_lat, cnt, mx;
  logic [31:0] e_rd, r_addr, r_wd;
  logic [3:0]  r_be;
  logic        e_err, r_we;

  initial begin
    for (int i = 0; i < 16; i++) mmem[i] = 32'hA5A5_0000 + i;
    mmem[0] = 32'hDEADBEEF;
    data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;

    // Reset: all outputs low even with a request pending.
    repeat (3) @(posedge clk_i);
    #2; data_req_i = 1; #1;
    check_zero("reset_outs");
    data_req_i = 0;
    rst_ni = 1;

    // Zero-wait load of 0x1000.
    do_txn(0, 32'h0000_1000, 4'hF, 32'h0, lat, na, nw);
    check_eq("load_lat", 64'(lat), 64'd3);

    // Store, wready three cycles after awready.
    w_dly = 3;
    do_txn(1, 32'h0000_1004, 4'b0011, 32'h1234_5678, lat, na, nw);
    check_eq("aw_cycles", 64'(na), 64'd1);
    check_eq("w_cycles", 64'(nw), 64'd4);
    w_dly = 0;

    // Error responses.
    rresp_cfg = 2'b10;
    do_txn(0, 32'h0000_1004, 4'hF, 32'h0, lat, na, nw);
    rresp_cfg = 2'b00; bresp_cfg = 2'b11;
    do_txn(1, 32'h0000_100C, 4'b1111, 32'h0BAD_F00D, lat, na, nw);
    bresp_cfg = 2'b00;

    // Request held through a stalled load: grant only in the pulse cycle.
    ar_dly = 5;
    model_exp(0, 32'h0000_1008, 4'hF, 32'h0, e_rd, e_err);
    issue(0, 32'h0000_1008, 4'hF, 32'h0);
    wait_resp(1, 0, 32'h0000_1008, 4'hF, 32'h0, e_rd, e_err, lat, na, nw);
    check_eq("hold_lat", 64'(lat), 64'd8);
    check_eq("gnt_b2b", 64'(data_gnt_o), 64'h1);
    wait_resp(0, 0, 32'h0000_1008, 4'hF, 32'h0, e_rd, e_err, lat, na, nw);
    check_eq("b2b_lat", 64'(lat), 64'd8);
    ar_dly = 0;

    // Reset asserted while waiting for the write response.
    b_dly = 6;
    model_exp(1, 32'h0000_1008, 4'b1100, 32'hCAFE_F00D, e_rd, e_err);
    issue(1, 32'h0000_1008, 4'b1100, 32'hCAFE_F00D);
    cnt = 0;
    for (int i = 0; i < 20 && cnt == 0; i++) begin
      @(posedge clk_i); #1; data_req_i = 0; #1; cnt = int'(m_bready);
    end
    check_eq("bready_seen", 64'(cnt), 64'h1);
    #1;
    data_we_i = 0; data_addr_i = 32'h0000_1008; data_be_i = 4'hF; data_wdata_i = 0;
    data_req_i = 1; rst_ni = 0;
    #1;
    check_zero("outs_in_rst");
    cnt = 0;
    repeat (3) begin @(posedge clk_i); #2; cnt += int'(data_rvalid_o); end
    check_eq("no_rvalid_rst", 64'(cnt), 64'h0);
    check_zero("outs_held_rst");
    #1; rst_ni = 1; b_dly = 0;
    #1;
    check_eq("gnt_after_rst", 64'(data_gnt_o), 64'h1);
    model_exp(0, 32'h0000_1008, 4'hF, 32'h0, e_rd, e_err);
    wait_resp(0, 0, 32'h0000_1008, 4'hF, 32'h0, e_rd, e_err, lat, na, nw);
    check_eq("rst_resume_lat", 64'(lat), 64'd3);

    // Randomized traffic against the memory model and latency rules.
    for (int t = 0; t < 40; t++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_addr = 32'h2000_0000 | ($urandom & 32'h3F);
      r_be   = 4'($urandom);
      r_wd   = $urandom;
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly  = $urandom_range(0, 3);
      rresp_cfg = 2'($urandom); bresp_cfg = 2'($urandom);
      mx = (aw_dly > w_dly) ? aw_dly : w_dly;
      exp_lat = r_we ? 3 + mx + b_dly : 3 + ar_dly + r_dly;
      do_txn(r_we, r_addr, r_be, r_wd, lat, na, nw);
      check_eq("rnd_lat", 64'(lat), 64'(exp_lat));
      check_eq("rnd_aw_cycles", 64'(na), r_we ? 64'(aw_dly + 1) : 64'd0);
      check_eq("rnd_w_cycles", 64'(nw), r_we ? 64'(w_dly + 1) : 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
